simd_bit_sequencer: RTL and testbench

Initiator-side controller that drives a group of bit-serial SIMD lanes through one ADD/SUB/MUL/DIV operation. It accepts an operation request over a valid/ready handshake and pulses the lane operand-load strobe. It then steps the bit index 0..BIT_WIDTH-1, issuing one bit strobe per step and collecting the per-lane done pulses before advancing. It reports completion, timeout and divide-by-zero status over a valid/ready response handshake, after which lane results are stable.

---
 rtl/simd_bit_sequencer.sv | 145 ++++++++++++++
 tb/tb_simd_bit_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_bit_sequencer.sv
// Initiator-side sequencer for bit-serial SIMD lanes: loads operands, steps bit indices,
// collects per-lane done pulses and returns completion / timeout / divide-by-zero status.
module simd_bit_sequencer #(
  parameter int BIT_WIDTH      = 32,
  parameter int NUM_LANES      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op_code,
  input  logic [NUM_LANES-1:0]         req_lane_mask,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         resp_timeout,
  output logic [NUM_LANES-1:0]         resp_fail_mask,
  output logic [NUM_LANES-1:0]         resp_dbz_mask,
  output logic                         busy,
  output logic                         lane_start_op,
  output logic                         lane_start_bit,
  output logic [$clog2(BIT_WIDTH)-1:0] lane_bit_select,
  output logic [1:0]                   lane_op_code,
  input  logic [NUM_LANES-1:0]         lane_done_bit,
  input  logic [NUM_LANES-1:0]         lane_div_by_zero
);

  localparam int SEL_W  = $clog2(BIT_WIDTH);
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SEL_W-1:0]  LAST_BIT  = SEL_W'(BIT_WIDTH - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_WAIT,
    S_RESP
  } state_t;

  // state is the FSM register; bind checkers to it directly.
  state_t               state;
  logic [NUM_LANES-1:0] mask;
  logic [NUM_LANES-1:0] done_seen;
  logic [NUM_LANES-1:0] done_now;
  logic [NUM_LANES-1:0] dbz_now;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 all_done;

  assign done_now = done_seen | (lane_done_bit & mask);
  assign all_done = (done_now == mask);
  assign dbz_now  = (lane_op_code == 2'd3) ? (lane_div_by_zero & mask) : '0;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
  // A raised valid and its payload stay unchanged until that edge; ready never depends on valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      req_ready       <= 1'b1;
      busy            <= 1'b0;
      resp_valid      <= 1'b0;
      resp_timeout    <= 1'b0;
      resp_fail_mask  <= '0;
      resp_dbz_mask   <= '0;
      lane_start_op   <= 1'b0;
      lane_start_bit  <= 1'b0;
      lane_bit_select <= '0;
      lane_op_code    <= '0;
      mask            <= '0;
      done_seen       <= '0;
      wait_cnt        <= '0;
    end else begin
      lane_start_op  <= 1'b0;
      lane_start_bit <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            lane_op_code    <= req_op_code;
            mask            <= req_lane_mask;
            lane_bit_select <= '0;
            req_ready       <= 1'b0;
            busy            <= 1'b1;
            lane_start_op   <= 1'b1;
            state           <= S_LOAD;
          end
        end
        S_LOAD: begin
          lane_bit_select <= '0;
          lane_start_bit  <= 1'b1;
          state           <= S_STEP;
        end
        S_STEP: begin
          done_seen <= '0;
          wait_cnt  <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // done pulses are single-cycle, so they accumulate until every enabled lane answered.
          done_seen <= done_now;
          if (all_done) begin
            if (lane_bit_select == LAST_BIT) begin
              resp_valid    <= 1'b1;
              resp_dbz_mask <= dbz_now;
              state         <= S_RESP;
            end else begin
              lane_bit_select <= lane_bit_select + 1'b1;
              lane_start_bit  <= 1'b1;
              state           <= S_STEP;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            resp_valid     <= 1'b1;
            resp_timeout   <= 1'b1;
            resp_fail_mask <= mask & ~done_now;
            resp_dbz_mask  <= dbz_now;
            state          <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid     <= 1'b0;
            resp_timeout   <= 1'b0;
            resp_fail_mask <= '0;
            resp_dbz_mask  <= '0;
            busy           <= 1'b0;
            req_ready      <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(lane_start_op && lane_start_bit));

  a_resp_held: assert property (@(posedge clk) disable iff (reset)
    (resp_valid && !resp_ready) |=>
      (resp_valid && $stable({resp_timeout, resp_fail_mask, resp_dbz_mask})));

endmodule

// File: tb/tb_simd_bit_sequencer.sv
// Bench for simd_bit_sequencer: behavioural lane responders, randomized operations and a
// scoreboard comparing each response against a timing/status model of the sequencing rules.
module tb_simd_bit_sequencer;

  localparam int BW = 8;
  localparam int NL = 4;
  localparam int TO = 16;
  localparam int SW = $clog2(BW);
  localparam int EW = 27;

  typedef struct packed {
    logic [1:0]                 op;
    logic [NL-1:0]              mask;
    logic [NL-1:0]              dbz;
    logic [BW-1:0][NL-1:0][5:0] dly;
  } desc_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op_code;
  logic [NL-1:0] req_lane_mask;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_timeout;
  logic [NL-1:0] resp_fail_mask;
  logic [NL-1:0] resp_dbz_mask;
  logic          busy;
  logic          lane_start_op;
  logic          lane_start_bit;
  logic [SW-1:0] lane_bit_select;
  logic [1:0]    lane_op_code;
  logic [NL-1:0] lane_done_bit;
  logic [NL-1:0] lane_div_by_zero;

  // Expected word: {op[26:25], timeout[24], fail[23:20], dbz[19:16], latency[15:0]}
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  desc_t         desc_q[$];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_hs = -100;
  int force_hold = -1;
  bit abort = 1'b0;

  simd_bit_sequencer #(
    .BIT_WIDTH(BW),
    .NUM_LANES(NL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op_code(req_op_code),
    .req_lane_mask(req_lane_mask),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_timeout(resp_timeout),
    .resp_fail_mask(resp_fail_mask),
    .resp_dbz_mask(resp_dbz_mask),
    .busy(busy),
    .lane_start_op(lane_start_op),
    .lane_start_bit(lane_start_bit),
    .lane_bit_select(lane_bit_select),
    .lane_op_code(lane_op_code),
    .lane_done_bit(lane_done_bit),
    .lane_div_by_zero(lane_div_by_zero)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 32'({req_ready, resp_valid, resp_timeout, resp_fail_mask, resp_dbz_mask, busy,
                     lane_start_op, lane_start_bit, lane_bit_select, lane_op_code}), 32'h40000);
  endtask

  // ---------------- reference model ----------------
  // Each bit step costs one STEP cycle plus as many WAIT cycles as the slowest enabled lane
  // (at least one). A lane slower than TO cycles, or silent, ends the operation with timeout.
  function automatic logic [EW-1:0] model(input desc_t d);
    int            t = 2;
    int            w;
    int            dl;
    int            lat = 0;
    logic          to = 1'b0;
    logic [NL-1:0] fail = '0;
    logic [NL-1:0] dbz;
    for (int k = 0; k < BW && !to; k++) begin
      w = 1;
      for (int l = 0; l < NL; l++) begin
        if (d.mask[l]) begin
          dl = int'(d.dly[k][l]);
          if (dl == 0 || dl > TO) fail[l] = 1'b1;
          else if (dl > w) w = dl;
        end
      end
      if (fail != '0) begin
        to  = 1'b1;
        lat = t + 1 + TO;
      end else begin
        t = t + 1 + w;
      end
    end
    if (!to) lat = t;
    dbz = (d.op == 2'd3) ? (d.dbz & d.mask) : '0;
    return {d.op, to, fail, dbz, 16'(lat)};
  endfunction

  function automatic desc_t mk(input logic [1:0] op, input logic [NL-1:0] mask,
                               input logic [NL-1:0] dbz, input int dall);
    desc_t d;
    d.op   = op;
    d.mask = mask;
    d.dbz  = dbz;
    for (int k = 0; k < BW; k++)
      for (int l = 0; l < NL; l++) d.dly[k][l] = 6'(dall);
    return d;
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    int    k;
    int    l;
    int    v;
    d.op   = 2'($urandom_range(0, 3));
    d.mask = ($urandom_range(0, 7) == 0) ? '0 : NL'($urandom);
    d.dbz  = NL'($urandom);
    for (int i = 0; i < BW; i++)
      for (int j = 0; j < NL; j++) d.dly[i][j] = 6'($urandom_range(1, 4));
    if ($urandom_range(0, 4) == 0) begin
      k = $urandom_range(0, BW - 1);
      l = $urandom_range(0, NL - 1);
      case ($urandom_range(0, 2))
        0:       v = 0;
        1:       v = TO;
        default: v = TO + 1;
      endcase
      d.dly[k][l] = 6'(v);
    end
    return d;
  endfunction

  // ---------------- lane responders ----------------
  // A lane with delay d pulses done d cycles after start_bit; delay 0 never answers.
  // Outside WAIT the done lines carry random noise that the sequencer must ignore.
  initial begin : lanes
    desc_t         cur;
    int            cnt[NL];
    logic [NL-1:0] dv;
    cur = '0;
    for (int l = 0; l < NL; l++) cnt[l] = 0;
    lane_done_bit    = '0;
    lane_div_by_zero = '0;
    forever begin
      @(negedge clk);
      dv = '0;
      if (reset) begin
        for (int l = 0; l < NL; l++) cnt[l] = 0;
      end else begin
        for (int l = 0; l < NL; l++) begin
          if (cnt[l] > 0) begin
            cnt[l]--;
            if (cnt[l] == 0) dv[l] = 1'b1;
          end
        end
        if (lane_start_op) begin
          if (desc_q.size() > 0) cur = desc_q.pop_front();
          for (int l = 0; l < NL; l++) cnt[l] = 0;
          lane_div_by_zero = cur.dbz;
        end
        if (lane_start_bit)
          for (int l = 0; l < NL; l++) cnt[l] = int'(cur.dly[lane_bit_select][l]);
        if (lane_start_op || lane_start_bit || resp_valid || !busy) dv = NL'($urandom);
      end
      lane_done_bit = dv;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit            in_resp = 1'b0;
    bit            post_hs = 1'b0;
    bit            stable_ok = 1'b1;
    int            hold = 0;
    int            step_idx = 0;
    int            lat;
    logic [EW-1:0] e;
    logic [8:0]    cap = '0;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_resp    = 1'b0;
        post_hs    = 1'b0;
        step_idx   = 0;
        resp_ready = 1'b0;
      end else begin
        if (post_hs) begin
          check("resp_clear", 32'({resp_valid, resp_timeout, resp_fail_mask, resp_dbz_mask, req_ready}),
                32'h001);
          post_hs = 1'b0;
        end
        if (lane_start_op) step_idx = 0;
        if (lane_start_bit) begin
          check("bit_select", 32'(lane_bit_select), 32'(step_idx));
          if (exp_q.size() > 0) check("lane_op_code", 32'(lane_op_code), 32'(exp_q[0][EW-1 -: 2]));
          else check("op_pending", 32'(exp_q.size()), 32'd1);
          step_idx++;
        end
        if (resp_valid) begin
          if (!in_resp) begin
            in_resp   = 1'b1;
            stable_ok = 1'b1;
            cap       = {resp_timeout, resp_fail_mask, resp_dbz_mask};
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
              check("unexpected_resp", 32'(exp_q.size()), 32'd1);
            end else begin
              e   = exp_q.pop_front();
              lat = cyc - acc_q.pop_front();
              check("resp_status", 32'(cap), 32'(e[24:16]));
              check("resp_latency", 32'(lat), 32'(e[15:0]));
            end
            hold       = (force_hold >= 0) ? force_hold : $urandom_range(0, 3);
            force_hold = -1;
          end else if (hold > 0) begin
            hold--;
          end
          if ({resp_timeout, resp_fail_mask, resp_dbz_mask} !== cap || req_ready !== 1'b0 ||
              lane_start_op !== 1'b0 || lane_start_bit !== 1'b0 || busy !== 1'b1)
            stable_ok = 1'b0;
          resp_ready = (hold == 0);
          if (resp_ready) begin
            check("resp_hold", 32'(stable_ok), 32'd1);
            last_hs = cyc;
            in_resp = 1'b0;
            post_hs = 1'b1;
          end
        end else begin
          if (in_resp) begin
            check("resp_dropped", 32'(resp_valid), 32'd1);
            in_resp = 1'b0;
          end
          resp_ready = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input desc_t d, input bit chk_b2b);
    bit got = 1'b0;
    if (abort) return;
    req_op_code   = d.op;
    req_lane_mask = d.mask;
    req_valid     = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("req_accept", 32'(req_ready), 32'd1);
      abort     = 1'b1;
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(d));
    acc_q.push_back(cyc);
    desc_q.push_back(d);
    if (chk_b2b) check("back_to_back", 32'(cyc), 32'(last_hs + 1));
    @(negedge clk);
    req_valid     = 1'b0;
    req_op_code   = 2'($urandom);
    req_lane_mask = NL'($urandom);
  endtask

  task automatic drain();
    if (abort) return;
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && !resp_valid) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      check("drain", 32'(exp_q.size()), 32'd0);
      abort = 1'b1;
    end
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    desc_t d;
    bit    found = 1'b0;
    req_valid     = 1'b0;
    req_op_code   = '0;
    req_lane_mask = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    @(negedge clk);

    d = mk(2'd0, 4'b1111, 4'b0000, 1);
    issue(d, 1'b0);
    d = mk(2'd3, 4'b1111, 4'b0100, 1);
    issue(d, 1'b1);
    d = mk(2'd0, 4'b1111, 4'b0000, 1);
    for (int k = 0; k < BW; k++) d.dly[k][1] = 6'd0;
    issue(d, 1'b1);
    d.mask = 4'b1101;
    issue(d, 1'b1);

    drain();
    force_hold = 5;
    d = mk(2'd1, 4'b1111, 4'b0000, 1);
    issue(d, 1'b0);
    d = mk(2'd2, 4'b1111, 4'b0000, 1);
    issue(d, 1'b1);

    for (int i = 0; i < 200 && !abort; i++) begin
      if (lane_start_bit && lane_bit_select == SW'(3)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) check("reach_bit3", 32'(lane_bit_select), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid_op");
    exp_q.delete();
    acc_q.delete();
    desc_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    d = mk(2'd2, 4'b1111, 4'b1111, 1);
    issue(d, 1'b0);
    drain();

    for (int n = 0; n < 40; n++) begin
      d = rand_desc();
      issue(d, n > 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
